// File: rtl/mux_scan_ctrl.sv
// rtl/mux_scan_ctrl.sv - scan sequencer driving an N:1 mux selector, streaming per-channel samples
// Optional continuous rescan from DONE when MUX_SCAN_CONT_EN is defined.
module mux_scan_ctrl #(
   parameter int muxSize       = 8,
   parameter int selectorSize  = $clog2(muxSize),
   parameter int SETTLE_CYCLES = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [muxSize-1:0]      ch_mask,
   output logic [selectorSize-1:0] selector,
   input  logic                    mux_q,
   output logic                    busy,
   output logic                    sample_valid,
   input  logic                    sample_ready,
   output logic [selectorSize-1:0] sample_ch,
   output logic                    sample_bit,
   output logic [muxSize-1:0]      word,
   output logic                    done
);

   localparam int CntW = $clog2(SETTLE_CYCLES + 1);
   localparam logic [CntW-1:0] CntLoad = CntW'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, SETTLE, OUT, DONE} state_t;

   state_t                  state_q, state_d;
   logic [muxSize-1:0]      mask_q, mask_d;
   logic [selectorSize-1:0] sel_q, sel_d;
   logic [CntW-1:0]         cnt_q, cnt_d;
   logic [muxSize-1:0]      word_q, word_d;
   logic [selectorSize-1:0] sample_ch_q, sample_ch_d;
   logic                    sample_bit_q, sample_bit_d;

   logic [selectorSize-1:0] next_sel;
   logic                    has_next;

   function automatic logic [selectorSize-1:0] lowest_set(input logic [muxSize-1:0] m);
      lowest_set = '0;
      for (int i = muxSize - 1; i >= 0; i--) begin
         if (m[i]) lowest_set = selectorSize'(i);
      end
   endfunction

   // Descending walk so the lowest enabled channel above the current one wins.
   always_comb begin
      next_sel = '0;
      has_next = 1'b0;
      for (int i = muxSize - 1; i >= 0; i--) begin
         if (mask_q[i] && (i > int'(sel_q))) begin
            next_sel = selectorSize'(i);
            has_next = 1'b1;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      mask_d       = mask_q;
      sel_d        = sel_q;
      cnt_d        = cnt_q;
      word_d       = word_q;
      sample_ch_d  = sample_ch_q;
      sample_bit_d = sample_bit_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               mask_d = ch_mask;
               word_d = '0;
               if (|ch_mask) begin
                  sel_d   = lowest_set(ch_mask);
                  cnt_d   = CntLoad;
                  state_d = SETTLE;
               end else begin
                  state_d = DONE;
               end
            end
         end
         SETTLE: begin
            if (cnt_q == '0) begin
               sample_bit_d  = mux_q;
               sample_ch_d   = sel_q;
               word_d[sel_q] = mux_q;
               state_d       = OUT;
            end else begin
               cnt_d = cnt_q - CntW'(1);
            end
         end
         OUT: begin
            if (sample_ready) begin
               if (has_next) begin
                  sel_d   = next_sel;
                  cnt_d   = CntLoad;
                  state_d = SETTLE;
               end else begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
`ifdef MUX_SCAN_CONT_EN
            if (start) begin
               word_d = '0;
               if (|mask_q) begin
                  sel_d   = lowest_set(mask_q);
                  cnt_d   = CntLoad;
                  state_d = SETTLE;
               end
            end else begin
               state_d = IDLE;
            end
`else
            state_d = IDLE;
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         mask_q       <= '0;
         sel_q        <= '0;
         cnt_q        <= '0;
         word_q       <= '0;
         sample_ch_q  <= '0;
         sample_bit_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         mask_q       <= mask_d;
         sel_q        <= sel_d;
         cnt_q        <= cnt_d;
         word_q       <= word_d;
         sample_ch_q  <= sample_ch_d;
         sample_bit_q <= sample_bit_d;
      end
   end

   assign selector     = sel_q;
   assign busy         = (state_q != IDLE);
   assign sample_valid = (state_q == OUT);
   assign sample_ch    = sample_ch_q;
   assign sample_bit   = sample_bit_q;
   assign word         = word_q;
   assign done         = (state_q == DONE);

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb/tb_mux_scan_ctrl.sv - directed bench for mux_scan_ctrl with a behavioural 8:1 mux (d=8'hA5)
module tb_mux_scan_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [7:0] ch_mask;
   logic [2:0] selector;
   logic       mux_q;
   logic       busy;
   logic       sample_valid;
   logic       sample_ready;
   logic [2:0] sample_ch;
   logic       sample_bit;
   logic [7:0] word;
   logic       done;

   logic [7:0] mux_d = 8'hA5;
   assign mux_q = mux_d[selector];

   always #5 clk = ~clk;

   mux_scan_ctrl #(.muxSize(8), .SETTLE_CYCLES(1)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .ch_mask(ch_mask),
      .selector(selector), .mux_q(mux_q), .busy(busy),
      .sample_valid(sample_valid), .sample_ready(sample_ready),
      .sample_ch(sample_ch), .sample_bit(sample_bit), .word(word), .done(done)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc;
   int n_hs, done_cyc, n_done, busy_low;
   logic [2:0] hs_ch  [16];
   logic       hs_bit [16];
   logic [7:0] word_at_done;
   logic       valid_seen, busy_after;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Start accepted at edge 0; cyc then counts cycles after that edge.
   task automatic run_scan(input logic [7:0] m, input int stall_ch, input int stall_len,
                           input int restart_cyc);
      int stall_left;
      ch_mask = m;
      start = 1'b1;
      cyc = 0;
      tick();
      start = 1'b0;
      n_hs = 0; done_cyc = -1; valid_seen = 1'b0; busy_low = 0; n_done = 0;
      stall_left = stall_len;
      while (done_cyc < 0 && cyc < 200) begin
         start = (cyc == restart_cyc);
         if (!busy) busy_low++;
         if (sample_valid) valid_seen = 1'b1;
         if (done) begin
            done_cyc = cyc;
            word_at_done = word;
         end else if (sample_valid) begin
            if (int'(sample_ch) == stall_ch && stall_left > 0) begin
               sample_ready = 1'b0;
               check("stall_valid", sample_valid, 1);
               check("stall_ch", sample_ch, 2);
               check("stall_bit", sample_bit, 1);
               check("stall_sel", selector, 2);
               stall_left--;
            end else begin
               sample_ready = 1'b1;
               if (n_hs < 16) begin
                  hs_ch[n_hs]  = sample_ch;
                  hs_bit[n_hs] = sample_bit;
               end
               n_hs++;
            end
         end
         tick();
      end
      start = 1'b0;
      if (done_cyc < 0) check("done_timeout", 0, 1);
      busy_after = busy;
      for (int k = 0; k < 20; k++) begin
         if (done) n_done++;
         tick();
      end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; ch_mask = 8'h00; sample_ready = 1'b1; cyc = 0;
      tick();
      tick();
      check("rst_selector", selector, 0);
      check("rst_busy", busy, 0);
      check("rst_valid", sample_valid, 0);
      check("rst_ch", sample_ch, 0);
      check("rst_bit", sample_bit, 0);
      check("rst_word", word, 0);
      check("rst_done", done, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Full mask
      run_scan(8'hFF, -1, 0, -1);
      check("ff_nhs", n_hs, 8);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("ff_ch%0d", i), hs_ch[i], i);
         check($sformatf("ff_bit%0d", i), hs_bit[i], mux_d[i]);
      end
      check("ff_done_cyc", done_cyc, 17);
      check("ff_word", word_at_done, 8'hA5);
      check("ff_busy_after", busy_after, 0);
      check("ff_busy_low", busy_low, 0);
      check("ff_word_hold", word, 8'hA5);

      // Sparse mask: selector jumps 0 -> 7
      run_scan(8'h81, -1, 0, -1);
      check("m81_nhs", n_hs, 2);
      check("m81_ch0", hs_ch[0], 0);
      check("m81_bit0", hs_bit[0], 1);
      check("m81_ch1", hs_ch[1], 7);
      check("m81_bit1", hs_bit[1], 1);
      check("m81_done_cyc", done_cyc, 5);
      check("m81_word", word_at_done, 8'h81);

      // Empty mask
      run_scan(8'h00, -1, 0, -1);
      check("m00_done_cyc", done_cyc, 1);
      check("m00_word", word_at_done, 8'h00);
      check("m00_valid_seen", valid_seen, 0);

      // Backpressure on ch2 for 5 cycles
      run_scan(8'hFF, 2, 5, -1);
      check("bp_nhs", n_hs, 8);
      check("bp_ch3", hs_ch[3], 3);
      check("bp_done_cyc", done_cyc, 22);
      check("bp_word", word_at_done, 8'hA5);

      // Start re-asserted during ch1 is ignored
      run_scan(8'hFF, -1, 0, 3);
      check("rs_done_cyc", done_cyc, 17);
      check("rs_word", word_at_done, 8'hA5);
      check("rs_extra_done", n_done, 0);

      // Reset during ch4 SETTLE
      ch_mask = 8'hFF;
      start = 1'b1;
      cyc = 0;
      tick();
      start = 1'b0;
      while (cyc < 9) tick();
      check("mid_sel4", selector, 4);
      check("mid_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_selector", selector, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_valid", sample_valid, 0);
      check("mid_rst_word", word, 0);
      check("mid_rst_done", done, 0);
      tick();
      check("mid_rst_done2", done, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("mid_post_done", done, 0);
      run_scan(8'hFF, -1, 0, -1);
      check("mid_rescan_done_cyc", done_cyc, 17);
      check("mid_rescan_word", word_at_done, 8'hA5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
